// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter: round-robin arbiter that feeds characters from several
// requesters into one serial transmitter using a tx_ce/tx_busy handshake.
// Optional packet locking is enabled by defining SERIAL_TX_ARB_LOCK_EN.
module serial_tx_arbiter #(
    parameter int unsigned Width      = 8,
    parameter int unsigned Requesters = 4,
    localparam int unsigned GidW      = (Requesters > 1) ? $clog2(Requesters) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [Requesters-1:0]        req,
    input  logic [Requesters*Width-1:0]  data,
    input  logic [Requesters-1:0]        last,
    output logic [Requesters-1:0]        ack,
    output logic [GidW-1:0]              grant_id,
    output logic                         tx_ce,
    output logic [Width-1:0]             tx_d,
    input  logic                         tx_busy,
    output logic                         idle,
    output logic                         err
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_LAUNCH    = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    localparam int unsigned TmoW          = 2;
    localparam int unsigned TimeoutCycles = 4;
    localparam logic [TmoW-1:0] TmoLast   = TmoW'(TimeoutCycles - 1);
    localparam logic [GidW-1:0] LastId    = GidW'(Requesters - 1);

    logic [1:0]            state_q, state_d;
    logic [Requesters-1:0] ack_q, ack_d;
    logic [GidW-1:0]       grant_id_q, grant_id_d;
    logic                  tx_ce_q, tx_ce_d;
    logic [Width-1:0]      tx_d_q, tx_d_d;
    logic                  idle_q, idle_d;
    logic                  err_q, err_d;
    logic [TmoW-1:0]       cnt_q, cnt_d;

    logic                  rr_found;
    logic [GidW-1:0]       rr_sel;
    logic                  grant_valid;
    logic [GidW-1:0]       sel_id;
    logic [Width-1:0]      sel_data;
    logic                  sel_last;

    // Round-robin search starting just after the previous grant.
    always_comb begin
        int unsigned cand;
        rr_found = 1'b0;
        rr_sel   = '0;
        cand     = 0;
        for (int unsigned off = 1; off <= Requesters; off++) begin
            cand = (32'(grant_id_q) + off) % Requesters;
            if (!rr_found && req[cand[GidW-1:0]]) begin
                rr_found = 1'b1;
                rr_sel   = cand[GidW-1:0];
            end
        end
    end

`ifdef SERIAL_TX_ARB_LOCK_EN
    logic lock_q, lock_d;
    logic lock_hit;

    // A held lock wins over round-robin while the owner keeps requesting.
    always_comb begin
        lock_hit    = lock_q && req[grant_id_q];
        sel_id      = lock_hit ? grant_id_q : rr_sel;
        grant_valid = lock_hit || rr_found;
    end
`else
    logic unused_last;
    assign unused_last = ^last;

    // Plain per-character round-robin.
    always_comb begin
        sel_id      = rr_sel;
        grant_valid = rr_found;
    end
`endif

    // Character and end-of-packet flag of the selected requester.
    always_comb begin
        sel_data = data[32'(sel_id) * Width +: Width];
        sel_last = last[sel_id];
    end

    // Next-state and registered-output logic of the launch FSM.
    always_comb begin
        state_d    = state_q;
        ack_d      = '0;
        grant_id_d = grant_id_q;
        tx_ce_d    = 1'b0;
        tx_d_d     = tx_d_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
`ifdef SERIAL_TX_ARB_LOCK_EN
        lock_d     = lock_q;
        if (lock_q && !req[grant_id_q]) begin
            lock_d = 1'b0;
        end
`endif
        case (state_q)
            S_IDLE: begin
                if (!tx_busy && grant_valid) begin
                    ack_d[sel_id] = 1'b1;
                    grant_id_d    = sel_id;
                    tx_d_d        = sel_data;
                    state_d       = S_LAUNCH;
`ifdef SERIAL_TX_ARB_LOCK_EN
                    lock_d        = !sel_last;
`endif
                end
            end
            S_LAUNCH: begin
                tx_ce_d = 1'b1;
                cnt_d   = '0;
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else if (cnt_q == TmoLast) begin
                    // Transmitter never started: drop the character, flag it.
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + TmoW'(1);
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        idle_d = (state_d == S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ack_q      <= '0;
            grant_id_q <= LastId;
            tx_ce_q    <= 1'b0;
            tx_d_q     <= '0;
            idle_q     <= 1'b1;
            err_q      <= 1'b0;
            cnt_q      <= '0;
`ifdef SERIAL_TX_ARB_LOCK_EN
            lock_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            grant_id_q <= grant_id_d;
            tx_ce_q    <= tx_ce_d;
            tx_d_q     <= tx_d_d;
            idle_q     <= idle_d;
            err_q      <= err_d;
            cnt_q      <= cnt_d;
`ifdef SERIAL_TX_ARB_LOCK_EN
            lock_q     <= lock_d;
`endif
        end
    end

    assign ack      = ack_q;
    assign grant_id = grant_id_q;
    assign tx_ce    = tx_ce_q;
    assign tx_d     = tx_d_q;
    assign idle     = idle_q;
    assign err      = err_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Scoreboard bench for serial_tx_arbiter with a simple transmitter model.
module tb_serial_tx_arbiter;

    localparam int unsigned W = 8;
    localparam int unsigned R = 4;
    localparam int unsigned FRAME = 3;

    typedef struct packed {
        logic [1:0]   id;
        logic [W-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [R-1:0] req = '0;
    logic [R*W-1:0] data = '0;
    logic [R-1:0] last = '0;
    logic [R-1:0] ack;
    logic [1:0]   grant_id;
    logic         tx_ce;
    logic [W-1:0] tx_d;
    logic         tx_busy;
    logic         idle;
    logic         err;

    int n_cmp  = 0;
    int n_fail = 0;

    exp_t       exp_q[$];
    logic [W-1:0] txq[$];
    logic [W-1:0] cq[R][$];
    logic         lq[R][$];

    logic tx_en = 1'b1;
    int   busy_cnt;

    serial_tx_arbiter #(.Width(W), .Requesters(R)) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .last(last),
        .ack(ack), .grant_id(grant_id), .tx_ce(tx_ce), .tx_d(tx_d),
        .tx_busy(tx_busy), .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for FRAME cycles after a start strobe.
    always @(posedge clk) begin
        if (rst) busy_cnt <= 0;
        else if (tx_ce && tx_en) busy_cnt <= FRAME;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic load(input int r, input logic [W-1:0] c, input logic l);
        cq[r].push_back(c);
        lq[r].push_back(l);
    endtask

    task automatic push_exp(input logic [1:0] id, input logic [W-1:0] d);
        exp_t e;
        e.id = id;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Requesters: present the head of each queue, advance on ack.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < R; i++) begin
                if (ack[i] && cq[i].size() > 0) begin
                    void'(cq[i].pop_front());
                    void'(lq[i].pop_front());
                end
            end
            for (int i = 0; i < R; i++) begin
                req[i]          = (cq[i].size() > 0);
                data[i*W +: W]  = (cq[i].size() > 0) ? cq[i][0] : '0;
                last[i]         = (lq[i].size() > 0) ? lq[i][0] : 1'b0;
            end
        end
    end

    // Monitor: compare every ack and every tx_ce against the scoreboard.
    initial begin
        exp_t e;
        logic [W-1:0] d;
        forever begin
            @(negedge clk);
            if (!rst && ack != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_ack", 32'(ack), 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_onehot", 32'(ack), 32'(4'b0001 << e.id));
                    chk("grant_id", 32'(grant_id), 32'(e.id));
                    txq.push_back(e.data);
                end
            end
            if (!rst && tx_ce) begin
                if (txq.size() == 0) begin
                    chk("unexpected_tx_ce", 32'(tx_ce), 32'h0);
                end else begin
                    d = txq.pop_front();
                    chk("tx_d", 32'(tx_d), 32'(d));
                end
            end
        end
    end

    task automatic wait_done(input int budget);
        bit ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && txq.size() == 0 && idle && !tx_busy && req == '0) begin
                ok = 1;
                break;
            end
        end
        chk("drain_timeout", 32'(ok), 32'h1);
    endtask

    task automatic wait_sig(input string name, input int which, input int budget);
        bit ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if ((which == 0 && tx_ce) || (which == 1 && tx_busy && !idle)) begin
                ok = 1;
                break;
            end
        end
        chk(name, 32'(ok), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_tx_ce", 32'(tx_ce), 32'h0);
        chk("rst_tx_d", 32'(tx_d), 32'h0);
        chk("rst_grant_id", 32'(grant_id), 32'h3);
        chk("rst_idle", 32'(idle), 32'h1);
        chk("rst_err", 32'(err), 32'h0);
        rst = 1'b0;

        // Single character from requester 0.
        @(negedge clk);
        load(0, 8'h55, 1'b1);
        push_exp(2'd0, 8'h55);
        wait_done(60);
        chk("t1_idle", 32'(idle), 32'h1);
        chk("t1_err", 32'(err), 32'h0);

        // All requesters pending after reset: 0,1,2,3,0.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load(0, 8'h11, 1'b1); load(0, 8'h12, 1'b1);
        load(1, 8'h21, 1'b1); load(2, 8'h31, 1'b1); load(3, 8'h41, 1'b1);
        push_exp(2'd0, 8'h11); push_exp(2'd1, 8'h21); push_exp(2'd2, 8'h31);
        push_exp(2'd3, 8'h41); push_exp(2'd0, 8'h12);
        wait_done(200);
        chk("t2_grant_id", 32'(grant_id), 32'h0);

        // Transmitter never starts: timeout sets a sticky err.
        tx_en = 1'b0;
        load(2, 8'h3C, 1'b1);
        push_exp(2'd2, 8'h3C);
        wait_sig("t3_wait_tx_ce", 0, 40);
        repeat (3) @(negedge clk);
        chk("t3_err_early", 32'(err), 32'h0);
        chk("t3_busy_phase", 32'(idle), 32'h0);
        @(negedge clk);
        chk("t3_err_set", 32'(err), 32'h1);
        chk("t3_idle", 32'(idle), 32'h1);
        repeat (5) @(negedge clk);
        chk("t3_err_hold", 32'(err), 32'h1);
        tx_en = 1'b1;
        load(3, 8'h7E, 1'b1);
        push_exp(2'd3, 8'h7E);
        wait_done(60);
        chk("t3_err_sticky", 32'(err), 32'h1);

        // Packet of three characters on requester 0 competing with requester 1.
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_err_cleared", 32'(err), 32'h0);
        chk("t4_grant_rst", 32'(grant_id), 32'h3);
        rst = 1'b0;
        load(0, 8'hA0, 1'b0); load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b1);
        load(1, 8'hB0, 1'b1); load(1, 8'hB1, 1'b1);
`ifdef SERIAL_TX_ARB_LOCK_EN
        push_exp(2'd0, 8'hA0); push_exp(2'd0, 8'hA1); push_exp(2'd0, 8'hA2);
        push_exp(2'd1, 8'hB0); push_exp(2'd1, 8'hB1);
`else
        push_exp(2'd0, 8'hA0); push_exp(2'd1, 8'hB0); push_exp(2'd0, 8'hA1);
        push_exp(2'd1, 8'hB1); push_exp(2'd0, 8'hA2);
`endif
        wait_done(250);

        // Reset while waiting for the frame to finish.
        load(2, 8'h5A, 1'b1);
        push_exp(2'd2, 8'h5A);
        wait_sig("t5_wait_busy", 1, 40);
        @(negedge clk);
        rst = 1'b1;
        load(3, 8'h6B, 1'b1);
        load(1, 8'h6A, 1'b1);
        push_exp(2'd1, 8'h6A);
        push_exp(2'd3, 8'h6B);
        @(negedge clk);
        chk("t5_tx_ce", 32'(tx_ce), 32'h0);
        chk("t5_ack", 32'(ack), 32'h0);
        chk("t5_grant_id", 32'(grant_id), 32'h3);
        chk("t5_idle", 32'(idle), 32'h1);
        rst = 1'b0;
        wait_done(120);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
